ase_fifo_rr_arbiter: RTL and testbench

Round-robin write arbiter that shares one ASE simulation FIFO write port among NUM_REQ requesters. Each requester presents valid/data/last bursts. The arbiter locks the FIFO to one requester for a whole burst, applies the FIFO's almost-full backpressure, and rotates fairly between bursts. It drives the FIFO's wr_en/data_in and reports grant status and a transfer count for the regression bench.

---
 rtl/ase_fifo_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_ase_fifo_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_fifo_rr_arbiter.sv
// ============================================================================
// ase_fifo_rr_arbiter: round-robin burst-locked write arbiter for one FIFO port
// Revision: 1.0
// ============================================================================
`default_nettype none

module ase_fifo_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_alm_full,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [CNT_WIDTH-1:0]          xfer_count,
    output logic                          wr_while_full
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IDW-1:0]        r_last_id;
    logic [IDW-1:0]        r_grant_id;
    logic                  r_grant_valid;
    logic [BCW-1:0]        r_beat_cnt;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_xfer_count;
    logic                  r_wr_while_full;

    logic                  w_sel_found;
    logic [IDW-1:0]        w_sel_id;
    logic [IDW-1:0]        w_idx;
    logic                  w_xfer;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_grant_data;

    // Round-robin search starts one past the previous holder and wraps.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((32'(r_last_id) + 32'(k)) % NUM_REQ);
            if (!w_sel_found && req_valid[w_idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_idx;
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDW'(i)) begin
                w_grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        w_xfer       = 1'b0;
        w_release    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found && !fifo_alm_full) begin
                    w_next_state = S_LOCK;
                end
            end
            S_LOCK: begin
                req_ready[r_grant_id] = !fifo_alm_full;
                w_xfer    = req_valid[r_grant_id] && !fifo_alm_full;
                w_release = w_xfer && (req_last[r_grant_id] ||
                            (r_beat_cnt == BCW'(MAX_BURST - 1)));
                if (w_release) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_last_id       <= IDW'(NUM_REQ - 1);
            r_grant_id      <= '0;
            r_grant_valid   <= 1'b0;
            r_beat_cnt      <= '0;
            r_wr_en         <= 1'b0;
            r_data          <= '0;
            r_xfer_count    <= '0;
            r_wr_while_full <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_wr_en         <= w_xfer;
            r_wr_while_full <= r_wr_while_full | (r_wr_en & fifo_full);
            if (w_xfer) begin
                r_data       <= w_grant_data;
                r_beat_cnt   <= r_beat_cnt + BCW'(1);
                r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
            end
            if (r_state == S_IDLE && w_next_state == S_LOCK) begin
                r_grant_id    <= w_sel_id;
                r_grant_valid <= 1'b1;
                r_beat_cnt    <= '0;
            end
            if (w_release) begin
                r_last_id     <= r_grant_id;
                r_grant_valid <= 1'b0;
            end
        end
    end

    assign fifo_wr_en    = r_wr_en;
    assign fifo_data_in  = r_data;
    assign grant_valid   = r_grant_valid;
    assign grant_id      = r_grant_id;
    assign xfer_count    = r_xfer_count;
    assign wr_while_full = r_wr_while_full;

endmodule

`default_nettype wire

// File: tb/tb_ase_fifo_rr_arbiter.sv
// ============================================================================
// tb_ase_fifo_rr_arbiter: scoreboard bench for the round-robin FIFO arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ase_fifo_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_last = '0;
    logic [NR-1:0]  req_ready;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_data_in;
    logic           fifo_alm_full = 1'b0;
    logic           fifo_full = 1'b0;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic [31:0]    xfer_count;
    logic           wr_while_full;

    ase_fifo_rr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (8),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_alm_full(fifo_alm_full),
        .fifo_full    (fifo_full),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .xfer_count   (xfer_count),
        .wr_while_full(wr_while_full)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] qd [NR][$];
    bit          ql [NR][$];
    logic [63:0] exp_wr [$];
    logic [1:0]  exp_gnt [$];

    int af_hold  = 0;
    bit af_prev  = 1'b0;
    bit chk_gap  = 1'b0;
    int last_gc  = -1;
    int cyc      = 0;
    bit prev_gv  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int id, input int s);
        return 64'hBEEF_0000_0000_0000 | (64'(id) << 16) | 64'(s);
    endfunction

    task automatic load(input int id, input int n, input bit all_last);
        for (int s = 0; s < n; s++) begin
            qd[id].push_back(beat(id, s));
            ql[id].push_back(all_last || (s == n - 1));
        end
    endtask

    task automatic ew(input int id, input int s);
        exp_wr.push_back(beat(id, s));
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            #3;
            if (qd[0].size() == 0 && qd[1].size() == 0 && qd[2].size() == 0 &&
                qd[3].size() == 0 && !grant_valid && !fifo_wr_en &&
                exp_wr.size() == 0 && exp_gnt.size() == 0)
                done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d writes and %0d grants outstanding, expected 0",
                     tag, exp_wr.size(), exp_gnt.size());
            exp_wr.delete();
            exp_gnt.delete();
            for (int i = 0; i < NR; i++) begin
                qd[i].delete();
                ql[i].delete();
            end
        end
    endtask

    // Requester driver: present queue heads, pop only on an accepted beat.
    always begin : drv
        logic [NR-1:0] acc;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (qd[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = qd[i][0];
                req_last[i]            = ql[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        fifo_alm_full = (af_hold > 0);
        if (af_hold > 0) af_hold = af_hold - 1;
        #1;
        acc = req_valid & req_ready;
        if (fifo_alm_full) begin
            chk("ready_under_almfull", 64'(req_ready), 64'd0);
            if (af_prev) chk("write_under_almfull", 64'(fifo_wr_en), 64'd0);
        end
        af_prev = fifo_alm_full;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    void'(qd[i].pop_front());
                    void'(ql[i].pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin : mon
        cyc++;
        if (fifo_wr_en) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got data %h, expected no write", fifo_data_in);
            end else begin
                chk("write_data", fifo_data_in, exp_wr.pop_front());
            end
        end
        if (grant_valid && !prev_gv) begin
            if (exp_gnt.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_grant: got id %0d, expected no grant", grant_id);
            end else begin
                chk("grant_id", 64'(grant_id), 64'(exp_gnt.pop_front()));
            end
            if (chk_gap) begin
                if (last_gc >= 0) chk("grant_gap", 64'(cyc - last_gc), 64'd2);
                last_gc = cyc;
            end
        end
        prev_gv = grant_valid;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gv"},    64'(grant_valid),   64'd0);
        chk({tag, "_gid"},   64'(grant_id),      64'd0);
        chk({tag, "_ready"}, 64'(req_ready),     64'd0);
        chk({tag, "_wren"},  64'(fifo_wr_en),    64'd0);
        chk({tag, "_data"},  fifo_data_in,       64'd0);
        chk({tag, "_xfer"},  64'(xfer_count),    64'd0);
        chk({tag, "_err"},   64'(wr_while_full), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single beat from requester 0
        qd[0].push_back(64'hA5);
        ql[0].push_back(1'b1);
        exp_gnt.push_back(2'd0);
        exp_wr.push_back(64'hA5);
        @(negedge clk); #2;
        chk("single_idle_gv", 64'(grant_valid), 64'd0);
        @(negedge clk); #2;
        chk("single_gv", 64'(grant_valid), 64'd1);
        chk("single_gid", 64'(grant_id), 64'd0);
        chk("single_ready", 64'(req_ready), 64'b0001);
        @(negedge clk); #2;
        chk("single_wren", 64'(fifo_wr_en), 64'd1);
        chk("single_released", 64'(grant_valid), 64'd0);
        chk("single_xfer", 64'(xfer_count), 64'd1);
        wait_idle("single");

        // Fairness: last holder was 0, so rotation starts at 1
        chk_gap = 1'b1;
        last_gc = -1;
        for (int i = 0; i < NR; i++) load(i, 2, 1'b1);
        for (int s = 0; s < 2; s++) begin
            exp_gnt.push_back(2'd1); ew(1, s);
            exp_gnt.push_back(2'd2); ew(2, s);
            exp_gnt.push_back(2'd3); ew(3, s);
            exp_gnt.push_back(2'd0); ew(0, s);
        end
        wait_idle("fair");
        chk_gap = 1'b0;
        chk("fair_xfer", 64'(xfer_count), 64'd9);

        // Burst lock: 2 holds for 3 beats, then 3 is searched before 1
        load(2, 3, 1'b0);
        @(negedge clk); #2;
        load(3, 1, 1'b1);
        load(1, 1, 1'b1);
        exp_gnt.push_back(2'd2); exp_gnt.push_back(2'd3); exp_gnt.push_back(2'd1);
        ew(2, 0); ew(2, 1); ew(2, 2); ew(3, 0); ew(1, 0);
        wait_idle("burst");
        chk("burst_xfer", 64'(xfer_count), 64'd14);

        // MAX_BURST: 12 beats from 1 split 8 + 4 around a grant to 3
        load(1, 12, 1'b0);
        @(negedge clk); #2;
        load(3, 1, 1'b1);
        exp_gnt.push_back(2'd1); exp_gnt.push_back(2'd3); exp_gnt.push_back(2'd1);
        for (int s = 0; s < 8; s++) ew(1, s);
        ew(3, 0);
        for (int s = 8; s < 12; s++) ew(1, s);
        wait_idle("maxburst");
        chk("maxburst_xfer", 64'(xfer_count), 64'd27);

        // Backpressure: alm_full for 5 cycles after two beats
        load(0, 6, 1'b0);
        exp_gnt.push_back(2'd0);
        for (int s = 0; s < 6; s++) ew(0, s);
        repeat (3) @(negedge clk);
        #2;
        af_hold = 5;
        wait_idle("bp");
        chk("bp_xfer", 64'(xfer_count), 64'd33);
        chk("bp_err", 64'(wr_while_full), 64'd0);

        // Reset during beat 2 of 4: only beat 0 reaches the FIFO
        load(2, 4, 1'b0);
        exp_gnt.push_back(2'd2);
        ew(2, 0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk); #2;
        for (int i = 0; i < NR; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        chk_all_zero("midrst");
        chk("midrst_wr_drained", 64'(exp_wr.size()), 64'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        load(1, 1, 1'b1);
        load(0, 1, 1'b1);
        exp_gnt.push_back(2'd0); exp_gnt.push_back(2'd1);
        ew(0, 0); ew(1, 0);
        wait_idle("postrst");
        chk("postrst_xfer", 64'(xfer_count), 64'd2);

        // Sticky error: full alone does nothing, a write while full sets it
        fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("err_no_write", 64'(wr_while_full), 64'd0);
        load(3, 1, 1'b1);
        exp_gnt.push_back(2'd3);
        ew(3, 0);
        wait_idle("err");
        fifo_full = 1'b0;
        @(negedge clk); #2;
        chk("err_sticky", 64'(wr_while_full), 64'd1);
        chk("err_xfer", 64'(xfer_count), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
